// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer state encoding and default timing constants.
package rst_seq_pkg;
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, READY} state_e;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 20000;
  localparam int DEF_STABLE_CYCLES       = 256;
  localparam int RETRY_MAX               = 15;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, async active-low reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, meta_d, sync_q, sync_d;
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end
  assign o_q = sync_q;
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: pulses the PLL reset, waits for a stable lock, then flags ready.
// Define RST_SEQ_RETRY_CNT_EN to add the saturating o_retry_count output.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  output logic       o_pll_reset,
  output logic       o_ready
`ifdef RST_SEQ_RETRY_CNT_EN
  ,
  output logic [3:0] o_retry_count
`endif
);
  localparam int MAX_A = PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pll_reset_q, pll_reset_d;
  logic            ready_q, ready_d;
  logic            lock_s;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_locked),
    .o_q     (lock_s)
  );

  // Lock is tested before timeout so a lock arriving on the last wait cycle wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLL_RST:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_d = STABLE; else if (cnt_q == TMO_LAST) state_d = PLL_RST;
      STABLE:    if (!lock_s) state_d = WAIT_LOCK; else if (cnt_q == STB_LAST) state_d = READY;
      default:   if (!lock_s) state_d = PLL_RST;
    endcase
    cnt_d       = (state_d != state_q || state_q == READY) ? '0 : cnt_q + 1'b1;
    pll_reset_d = state_d == PLL_RST;
    ready_d     = state_d == READY;
  end

`ifdef RST_SEQ_RETRY_CNT_EN
  logic [3:0] retry_q, retry_d;
  // Every entry into PLL_RST after reset release is a retry.
  always_comb
    retry_d = (state_d == PLL_RST && state_q != PLL_RST && retry_q != 4'(RETRY_MAX))
              ? retry_q + 4'd1 : retry_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
  assign o_retry_count = retry_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
    end
  end

  assign o_pll_reset = pll_reset_q;
  assign o_ready     = ready_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed scoreboard bench for rst_sequencer (PLL_RST=4, TIMEOUT=32, STABLE=8).
module tb_rst_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       pll_reset;
  logic       ready;
  logic [3:0] retry;

  always #5 clk = ~clk;

  rst_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .STABLE_CYCLES       (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pll_locked  (locked),
    .o_pll_reset   (pll_reset),
    .o_ready       (ready)
`ifdef RST_SEQ_RETRY_CNT_EN
    ,
    .o_retry_count (retry)
`endif
  );

`ifndef RST_SEQ_RETRY_CNT_EN
  assign retry = 4'd0;
`endif

  typedef struct {
    int         id;
    logic       rst;
    logic       rdy;
    logic [3:0] rc;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL scoreboard_empty observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    n_asserts++;
    assert (pll_reset === e.rst) else begin
      n_fail++;
      $error("FAIL step %0d pll_reset observed %b expected %b", e.id, pll_reset, e.rst);
    end
    n_asserts++;
    assert (ready === e.rdy) else begin
      n_fail++;
      $error("FAIL step %0d ready observed %b expected %b", e.id, ready, e.rdy);
    end
`ifdef RST_SEQ_RETRY_CNT_EN
    n_asserts++;
    assert (retry === e.rc) else begin
      n_fail++;
      $error("FAIL step %0d retry observed %0d expected %0d", e.id, retry, e.rc);
    end
`endif
  endtask

  task automatic step(input logic lk, input int id, input logic er, input logic erd, input int erc);
    locked = lk;
    sb.push_back('{id, er, erd, 4'(erc)});
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  task automatic reset_pulse(input int id);
    rst_n  = 1'b0;
    locked = 1'b0;
    #1;
    sb.push_back('{id, 1'b1, 1'b0, 4'd0});
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb.push_back('{id + 1, 1'b1, 1'b0, 4'd0});
    check_pop();
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    reset_pulse(0);
    // Lock at edge 10, loss at 26 (ready drop at 28), relock exactly on the timeout cycle.
    for (int k = 1; k <= 80; k++)
      step((k >= 10 && k < 26) || k >= 62, 1000 + k,
           k < 4 || (k >= 28 && k < 32),
           (k >= 20 && k < 28) || k >= 72,
           k >= 28 ? 1 : 0);
    // Asynchronous reset while READY.
    @(negedge clk);
    locked = 1'b1;
    @(posedge clk);
    #2;
    reset_pulse(2000);
    // One-cycle lock glitch during STABLE: back to WAIT_LOCK, no retry.
    for (int j = 1; j <= 30; j++)
      step((j >= 10 && j < 15) || j >= 16, 3000 + j, j < 4, j >= 26, 0);
    // Lock never arrives: reset re-pulses every 36 cycles, retries saturate at 15.
    reset_pulse(4000);
    for (int j = 1; j <= 36 * 17 + 4; j++)
      step(1'b0, 5000 + j, (j % 36) < 4, 1'b0, (j / 36) > 15 ? 15 : j / 36);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The module SHALL have parameter PLL_RST_CYCLES, default 16: cycles o_pll_reset is held high per attempt (minimum 1).
REQ-002 The module SHALL have parameter LOCK_TIMEOUT_CYCLES, default 20000 (100 us at 200 MHz): cycles allowed for lock before retry.
REQ-003 The module SHALL have parameter STABLE_CYCLES, default 256: consecutive locked cycles required before ready.
REQ-004 The module SHALL have port i_clk, input, 1 bit: free-running 200 MHz reference clock, the same clock that drives the PLL input.
REQ-005 The module SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port i_pll_locked, input, 1 bit: PLL LOCKED, asynchronous to i_clk.
REQ-007 The module SHALL have port o_pll_reset, output, 1 bit: active-high reset to the PLL RST pin.
REQ-008 The module SHALL have port o_ready, output, 1 bit: PLL output clock is locked and stable, so downstream logic may leave reset.
REQ-009 The module SHALL have port o_retry_count, output, 4 bits: saturating count of PLL reset retries (present only under REQ-027).

Function
REQ-010 i_pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes the second flop; no other logic samples i_pll_locked.
REQ-011 The FSM SHALL have four states: PLL_RST, WAIT_LOCK, STABLE and READY; a single counter is cleared on every state transition.
REQ-012 PLL_RST: o_pll_reset=1; after exactly PLL_RST_CYCLES cycles the FSM moves to WAIT_LOCK.
REQ-013 WAIT_LOCK: o_pll_reset=0; if lock_s=1 the FSM moves to STABLE.
REQ-014 WAIT_LOCK: if the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, the FSM moves to PLL_RST and the retry count is incremented.
REQ-015 When timeout and lock_s=1 coincide in the same cycle, lock SHALL win and the FSM moves to STABLE.
REQ-016 STABLE: lock_s=0 moves the FSM to WAIT_LOCK (no retry increment); STABLE_CYCLES consecutive cycles of lock_s=1 move it to READY.
REQ-017 READY: o_ready=1; lock_s=0 moves the FSM to PLL_RST, increments the retry count, and drops o_ready in the same edge.
REQ-018 o_ready and o_pll_reset SHALL be registered, with no combinational path from any input.
REQ-019 o_ready SHALL rise exactly STABLE_CYCLES+2 clock edges after the first edge that samples i_pll_locked=1, provided lock holds.
REQ-020 The retry count SHALL saturate at 15 and never wrap; only i_rst_n clears it.
REQ-021 The counter width SHALL be $clog2 of the largest of the three parameters, plus 1.

Reset
REQ-022 On i_rst_n=0 the outputs SHALL asynchronously take: state=PLL_RST, counter=0, synchronizer=0, o_pll_reset=1, o_ready=0, retry count=0.
REQ-023 The integrator SHALL deliver i_rst_n deassertion synchronous to i_clk.
REQ-024 Reset asserted mid-operation, including in READY, SHALL drop o_ready immediately and restart the full sequence.
REQ-025 PLL_RST timing SHALL count from the first edge after reset release.

Configuration
REQ-026 The macro RST_SEQ_RETRY_CNT_EN SHALL control the retry counter.
REQ-027 With RST_SEQ_RETRY_CNT_EN defined: the o_retry_count port and its counter exist.
REQ-028 Without RST_SEQ_RETRY_CNT_EN: the port and counter are absent, and FSM behaviour is otherwise identical.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-030 Sub-module sync_2ff SHALL implement the locked synchronizer, with async active-low reset to 0.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8.
REQ-031 Reset release, locked rises 10 cycles later -> o_pll_reset high for exactly 4 cycles; o_ready rises 10 edges after locked is sampled.
REQ-032 Locked never rises -> o_pll_reset re-pulses every 4+32 cycles; retry count 1,2,...,15, then holds at 15.
REQ-033 Locked high 5 cycles, low 1 cycle, then high -> FSM returns to WAIT_LOCK with no retry increment; o_ready rises 10 edges after the final rise.
REQ-034 In READY, locked drops -> o_ready=0 and o_pll_reset=1 within 3 edges; retry count +1.
REQ-035 Locked rises on the timeout cycle -> FSM goes to STABLE, not PLL_RST; retry count unchanged.
REQ-036 i_rst_n pulsed low while in READY -> all outputs take their reset values immediately; build without RST_SEQ_RETRY_CNT_EN passes REQ-031.
